// File: rtl/cdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdm_pkg : shared types, default sizes and reference model for the  |
// |           iterative carry-disregard multiplier                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cdm_pkg;

    localparam int c_default_w = 8;
    localparam int c_default_k = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cdm_state_t;

    // Behavioural CDM result for operands up to 32 bits.
    function automatic logic [63:0] cdm_ref(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input int k, input logic approx);
        logic [63:0] mask;
        logic [63:0] row;
        logic [63:0] lo;
        logic [63:0] hi;
        mask = (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
        lo   = '0;
        hi   = '0;
        if (!approx) return {32'd0, a} * {32'd0, b};
        for (int j = 0; j < w; j++) begin
            row = b[j] ? ({32'd0, a} << j) : 64'd0;
            lo  = lo | (row & mask);
            hi  = hi + (row & ~mask);
        end
        return lo | hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdm_row_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdm_row_acc : one partial-product row plus split OR/ADD accumulate |
// |               (optional exact accumulator under CDM_ERRDIST_EN)    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cdm_row_acc #(
    parameter int W  = 8,
    parameter int K  = 8,
    parameter int JW = 3
) (
    input  logic [W-1:0]   i_a,
    input  logic           i_b_bit,
    input  logic [JW-1:0]  i_j,
    input  logic           i_approx,
    input  logic [2*W-1:0] i_acc,
    output logic [2*W-1:0] o_acc_next
`ifdef CDM_ERRDIST_EN
    ,
    input  logic [2*W-1:0] i_acc_exact,
    output logic [2*W-1:0] o_acc_exact_next
`endif
);

    // Low K columns are OR-merged; high columns are added with no carry-in from below.
    localparam logic [2*W-1:0] c_lo_mask = (K == 0) ? '0 : ({(2*W){1'b1}} >> (2*W-K));

    logic [2*W-1:0] w_row;
    logic [2*W-1:0] w_exact;
    logic [2*W-1:0] w_approx;

    assign w_row    = {{W{1'b0}}, (i_a & {W{i_b_bit}})} << i_j;
    assign w_exact  = i_acc + w_row;
    assign w_approx = ((i_acc | w_row) & c_lo_mask)
                    | ((i_acc & ~c_lo_mask) + (w_row & ~c_lo_mask));

    assign o_acc_next = i_approx ? w_approx : w_exact;

`ifdef CDM_ERRDIST_EN
    assign o_acc_exact_next = i_acc_exact + w_row;
`endif

endmodule
`default_nettype wire

// File: rtl/cdm_iter_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdm_iter_mult : W x W iterative carry-disregard multiplier with    |
// |                 valid/ready handshakes; CDM_ERRDIST_EN adds ERR    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cdm_iter_mult
    import cdm_pkg::*;
#(
    parameter int W = c_default_w,
    parameter int K = c_default_k
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           approx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] R
`ifdef CDM_ERRDIST_EN
    ,
    output logic [2*W-1:0] ERR
`endif
);

    localparam int             c_jw     = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_jw-1:0] c_j_last = c_jw'(W - 1);

    cdm_state_t     r_state;
    cdm_state_t     w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_approx;
    logic [c_jw-1:0] r_j;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] w_acc_next;
`ifdef CDM_ERRDIST_EN
    logic [2*W-1:0] r_acc_exact;
    logic [2*W-1:0] w_acc_exact_next;
`endif

    cdm_row_acc #(.W(W), .K(K), .JW(c_jw)) u_row_acc (
        .i_a              (r_a),
        .i_b_bit          (r_b[r_j]),
        .i_j              (r_j),
        .i_approx         (r_approx),
        .i_acc            (r_acc),
        .o_acc_next       (w_acc_next)
`ifdef CDM_ERRDIST_EN
        ,
        .i_acc_exact      (r_acc_exact),
        .o_acc_exact_next (w_acc_exact_next)
`endif
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_j == c_j_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_approx    <= 1'b0;
            r_j         <= '0;
            r_acc       <= '0;
`ifdef CDM_ERRDIST_EN
            r_acc_exact <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a         <= A;
                        r_b         <= B;
                        r_approx    <= approx;
                        r_j         <= '0;
                        r_acc       <= '0;
`ifdef CDM_ERRDIST_EN
                        r_acc_exact <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    r_acc       <= w_acc_next;
`ifdef CDM_ERRDIST_EN
                    r_acc_exact <= w_acc_exact_next;
`endif
                    r_j         <= r_j + c_jw'(1);
                end
                default: ;
            endcase
        end
    end

    assign R = r_acc;
`ifdef CDM_ERRDIST_EN
    assign ERR = r_acc_exact - r_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdm_iter_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cdm_iter_mult : directed checks of three cdm_iter_mult configs  |
// |                    (W2K2, W8K4, W8K8) driven in lockstep           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cdm_iter_mult;
    import cdm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, approx, out_ready;
    logic [7:0]  a, b;
    logic        ir2, ov2, ir84, ov84, ir88, ov88;
    logic [3:0]  r2;
    logic [15:0] r84, r88;
`ifdef CDM_ERRDIST_EN
    logic [3:0]  e2;
    logic [15:0] e84, e88;
`endif

    int          n_vec = 0;
    int          n_fail = 0;
    int          lat2, lat84, lat88;
    logic [3:0]  cap2;
    logic [15:0] cap84, cap88;
    logic [3:0]  ecap2;
    logic [15:0] ecap84, ecap88;

    always #5 clk = ~clk;

    cdm_iter_mult #(.W(2), .K(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .A(a[1:0]), .B(b[1:0]), .approx(approx), .out_valid(ov2),
        .out_ready(out_ready), .R(r2)
`ifdef CDM_ERRDIST_EN
        , .ERR(e2)
`endif
    );

    cdm_iter_mult #(.W(8), .K(4)) dut84 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir84),
        .A(a), .B(b), .approx(approx), .out_valid(ov84),
        .out_ready(out_ready), .R(r84)
`ifdef CDM_ERRDIST_EN
        , .ERR(e84)
`endif
    );

    cdm_iter_mult #(.W(8), .K(8)) dut88 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir88),
        .A(a), .B(b), .approx(approx), .out_valid(ov88),
        .out_ready(out_ready), .R(r88)
`ifdef CDM_ERRDIST_EN
        , .ERR(e88)
`endif
    );

    // Present one operand pair to all three blocks, capture each first result, then release.
    task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic iap);
        int cyc;
        lat2 = 0; lat84 = 0; lat88 = 0;
        cap2 = 'x; cap84 = 'x; cap88 = 'x;
        ecap2 = 'x; ecap84 = 'x; ecap88 = 'x;
        a = ia; b = ib; approx = iap; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ia; b = ~ib; approx = ~iap;
        cyc = 1;
        while (cyc < 40) begin
            if (lat2 == 0 && ov2) begin
                lat2 = cyc; cap2 = r2;
`ifdef CDM_ERRDIST_EN
                ecap2 = e2;
`endif
            end
            if (lat84 == 0 && ov84) begin
                lat84 = cyc; cap84 = r84;
`ifdef CDM_ERRDIST_EN
                ecap84 = e84;
`endif
            end
            if (lat88 == 0 && ov88) begin
                lat88 = cyc; cap88 = r88;
`ifdef CDM_ERRDIST_EN
                ecap88 = e88;
`endif
            end
            if (lat2 != 0 && lat84 != 0 && lat88 != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; approx = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ir2 !== 1'b1 || ir84 !== 1'b1 || ir88 !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b%b%b expected 111", ir2, ir84, ir88); end
        n_vec++; if (ov2 !== 1'b0 || ov84 !== 1'b0 || ov88 !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid: got %b%b%b expected 000", ov2, ov84, ov88); end
        n_vec++; if (r2 !== 4'd0 || r84 !== 16'd0 || r88 !== 16'd0) begin n_fail++;
            $display("FAIL reset_R: got %0d/%0d/%0d expected 0/0/0", r2, r84, r88); end
`ifdef CDM_ERRDIST_EN
        n_vec++; if (e2 !== 4'd0 || e84 !== 16'd0 || e88 !== 16'd0) begin n_fail++;
            $display("FAIL reset_ERR: got %0d/%0d/%0d expected 0", e2, e84, e88); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_small_w();
        op(8'd3, 8'd3, 1'b1);
        n_vec++; if (lat2 !== 3) begin n_fail++;
            $display("FAIL w2_latency: got %0d expected 3", lat2); end
        n_vec++; if (cap2 !== 4'd7) begin n_fail++;
            $display("FAIL w2_approx_3x3: got %0d expected 7", cap2); end
`ifdef CDM_ERRDIST_EN
        n_vec++; if (ecap2 !== 4'd2) begin n_fail++;
            $display("FAIL w2_err_3x3: got %0d expected 2", ecap2); end
`endif
        op(8'd3, 8'd3, 1'b0);
        n_vec++; if (cap2 !== 4'd9) begin n_fail++;
            $display("FAIL w2_exact_3x3: got %0d expected 9", cap2); end
    endtask

    task automatic test_partial_k();
        op(8'd15, 8'd15, 1'b1);
        n_vec++; if (lat84 !== 9 || lat88 !== 9) begin n_fail++;
            $display("FAIL w8_latency: got %0d/%0d expected 9", lat84, lat88); end
        n_vec++; if (cap84 !== 16'd191) begin n_fail++;
            $display("FAIL k4_approx_15x15: got %0d expected 191", cap84); end
        n_vec++; if (cap88 !== 16'd127) begin n_fail++;
            $display("FAIL k8_approx_15x15: got %0d expected 127", cap88); end
`ifdef CDM_ERRDIST_EN
        n_vec++; if (ecap84 !== 16'd34 || ecap88 !== 16'd98) begin n_fail++;
            $display("FAIL err_15x15: got %0d/%0d expected 34/98", ecap84, ecap88); end
`endif
        op(8'd15, 8'd15, 1'b0);
        n_vec++; if (cap84 !== 16'd225 || cap88 !== 16'd225) begin n_fail++;
            $display("FAIL exact_15x15: got %0d/%0d expected 225", cap84, cap88); end
`ifdef CDM_ERRDIST_EN
        n_vec++; if (ecap84 !== 16'd0 || ecap88 !== 16'd0) begin n_fail++;
            $display("FAIL err_exact_mode: got %0d/%0d expected 0", ecap84, ecap88); end
`endif
    endtask

    task automatic test_boundary();
        op(8'd255, 8'd1, 1'b1);
        n_vec++; if (cap88 !== 16'd255 || cap84 !== 16'd255 || cap2 !== 4'd3) begin n_fail++;
            $display("FAIL single_row: got %0d/%0d/%0d expected 255/255/3", cap88, cap84, cap2); end
        op(8'd0, 8'd200, 1'b1);
        n_vec++; if (cap88 !== 16'd0 || cap84 !== 16'd0 || cap2 !== 4'd0) begin n_fail++;
            $display("FAIL zero_operand: got %0d/%0d/%0d expected 0", cap88, cap84, cap2); end
        op(8'd200, 8'd3, 1'b1);
        n_vec++; if (cap88 !== 16'd472 || cap84 !== 16'd600 || cap2 !== 4'd0) begin n_fail++;
            $display("FAIL approx_200x3: got %0d/%0d/%0d expected 472/600/0", cap88, cap84, cap2); end
    endtask

    task automatic test_backpressure();
        int cyc;
        a = 8'd15; b = 8'd15; approx = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'd255; b = 8'd255; approx = 1'b0;   // in_valid held while busy: must be ignored
        cyc = 0;
        while (!ov88 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_vec++; if (ov88 !== 1'b1) begin n_fail++;
            $display("FAIL bp_timeout: got out_valid=%b expected 1", ov88); end
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (ov88 !== 1'b1 || r88 !== 16'd127 || ir88 !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b R=%0d ir=%b expected ov=1 R=127 ir=0", i, ov88, r88, ir88); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++; if (ov88 !== 1'b0 || ir88 !== 1'b1) begin n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", ov88, ir88); end
    endtask

    task automatic test_reset_mid_run();
        a = 8'd200; b = 8'd3; approx = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (ov88 !== 1'b0 || ir88 !== 1'b1 || r88 !== 16'd0) begin n_fail++;
            $display("FAIL mid_run_reset: got ov=%b ir=%b R=%0d expected 0/1/0", ov88, ir88, r88); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(8'd3, 8'd5, 1'b1);
        n_vec++; if (cap88 !== 16'd15 || lat88 !== 9) begin n_fail++;
            $display("FAIL after_reset_3x5: got R=%0d lat=%0d expected 15/9", cap88, lat88); end
    endtask

    task automatic test_sweep();
        logic [7:0]  sa, sb;
        logic        sap;
        logic [63:0] m;
        logic [15:0] p;
        for (int i = 0; i < 120; i++) begin
            sa = 8'($urandom); sb = 8'($urandom); sap = i[0];
            op(sa, sb, sap);
            p = 16'(sa) * 16'(sb);
            m = cdm_ref({24'd0, sa}, {24'd0, sb}, 8, 8, sap);
            n_vec++; if (cap88 !== m[15:0]) begin n_fail++;
                $display("FAIL sweep_k8 %0dx%0d ap=%b: got %0d expected %0d", sa, sb, sap, cap88, m[15:0]); end
            m = cdm_ref({24'd0, sa}, {24'd0, sb}, 8, 4, sap);
            n_vec++; if (cap84 !== m[15:0]) begin n_fail++;
                $display("FAIL sweep_k4 %0dx%0d ap=%b: got %0d expected %0d", sa, sb, sap, cap84, m[15:0]); end
            m = cdm_ref({30'd0, sa[1:0]}, {30'd0, sb[1:0]}, 2, 2, sap);
            n_vec++; if (cap2 !== m[3:0]) begin n_fail++;
                $display("FAIL sweep_w2 %0dx%0d ap=%b: got %0d expected %0d", sa[1:0], sb[1:0], sap, cap2, m[3:0]); end
            if (!sap) begin
                n_vec++; if (cap88 !== p) begin n_fail++;
                    $display("FAIL sweep_exact %0dx%0d: got %0d expected %0d", sa, sb, cap88, p); end
            end else begin
                n_vec++; if (cap88 > p || cap84 > p) begin n_fail++;
                    $display("FAIL sweep_bound %0dx%0d: got %0d/%0d expected <= %0d", sa, sb, cap88, cap84, p); end
            end
`ifdef CDM_ERRDIST_EN
            n_vec++; if (ecap88 !== (p - cap88)) begin n_fail++;
                $display("FAIL sweep_err %0dx%0d: got %0d expected %0d", sa, sb, ecap88, p - cap88); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_small_w();
        test_partial_k();
        test_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdm_iter_mult.md
Name: cdm_iter_mult

Overview:
- Parametrised, multi-cycle successor to the fixed 8-bit carry-disregard multiplier (CDM).
- Computes a W x W unsigned product one partial-product row per cycle.
- In the K least-significant columns, carries are disregarded: each column bit is the OR of its partial-product bits, and nothing propagates out of the low region. Columns >= K are summed exactly.
- Sits between operand sources and result consumers via valid/ready handshakes. A runtime mode selects exact or approximate operation.

Parameters:
- W, 8, operand width in bits (2..32).
- K, 8, number of carry-disregard low columns (0..2W-1); K=0 gives an exact multiplier.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands
- A  input  W  multiplicand, unsigned
- B  input  W  multiplier, unsigned
- approx  input  1  1 = carry-disregard result, 0 = exact; sampled at accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- R  output  2W  product

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - State -> IDLE; in_ready=1, out_valid=0, R=0.
  - All internal registers are cleared.
  - Any in-flight operation is abandoned; no result is emitted for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A, B and approx; clear acc_lo (K bits) and acc_hi (2W-K bits); row index j=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: row = (A & {W{B[j]}}) << j, 2W bits wide.
  - If approx=1: acc_lo |= row[K-1:0] and acc_hi += row[2W-1:K].
  - If approx=0: full exact accumulation into {acc_hi,acc_lo}.
  - j increments each cycle. After j=W-1 is processed, go to DONE.
- Latency: exactly W cycles spent in RUN.
- DONE:
  - out_valid=1, R={acc_hi,acc_lo}.
  - R holds stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops on the next cycle.
- Throughput: one result per W+2 cycles. No accept in DONE (in_ready=0), so there is no overlap.
- Arithmetic:
  - acc_hi is 2W-K bits wide; its sum never overflows, because the exact product fits in 2W bits.
  - In approximate mode R <= exact product always holds.
- Boundary cases:
  - K=0: approx has no effect.
  - B=0 or A=0: R=0.
  - in_valid asserted while the block is busy is ignored; the source must hold it until in_ready.
  - Inputs A, B and approx are don't-care outside the accept cycle.

Optional Feature:
- Macro CDM_ERRDIST_EN.
- When defined:
  - Adds output ERR (2W bits) = exact product - R.
  - A parallel exact accumulator is maintained during RUN.
  - ERR is valid with out_valid, reset value 0, held stable under backpressure.
  - In exact mode ERR=0.
- When undefined: no ERR port and no exact accumulator; area is minimal.

Decomposition:
- Shared package cdm_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Default W/K constants.
  - A function for the reference CDM model, used by benches.
- One natural sub-module, cdm_row_acc: the combinational row generation plus split OR/ADD accumulate step. It is parametrised by W and K and instantiated once.

Test Plan:
- W=2, K=2, approx=1: A=3, B=3 -> R=7 (exact 9; ERR=2 if CDM_ERRDIST_EN); out_valid rises W+1 cycles after accept.
- W=8, K=4, approx=1: A=15, B=15 -> R=191 (exact 225, ERR=34). Same operands with approx=0 -> R=225, ERR=0.
- W=8, K=8: A=255, B=1 -> R=255 (single row, no error). A=0, B=200 -> R=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> R and out_valid held constant; in_ready=0 throughout; accept completes when out_ready=1.
- Reset mid-RUN: assert rst_n=0 at j=3 -> next cycle out_valid=0, in_ready=1, R=0. A new operation A=3, B=5 (W=8, K=8) completes with R=15.
- Sweep: W=8, K=8, all 65536 A/B pairs in both modes -> R matches the cdm_pkg model. Exact mode equals A*B.
